// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - round-robin register-file write-port arbiter with clear sequencer
// Optional RF_ARB_ZERO_GUARD_EN: granted writes to address 0 are accepted but dropped (hardwired r0).
module regfile_wr_arbiter #(
    parameter int NREQ  = 3,
    parameter int AW    = 5,
    parameter int DW    = 32,
    parameter int NREGS = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    iReq,
    input  logic [NREQ*AW-1:0] iReqAddr,
    input  logic [NREQ*DW-1:0] iReqData,
    output logic [NREQ-1:0]    oGrant,
    input  logic               iClear,
    output logic               oBusy,
    output logic [AW-1:0]      oWAddr,
    output logic [DW-1:0]      oWData,
    output logic               oWe
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        ST_ARB,
        ST_CLEAR
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   rr_q, rr_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [AW-1:0]   waddr_q, waddr_d;
    logic [DW-1:0]   wdata_q, wdata_d;

    logic [NREQ-1:0] grant;
    logic            found;
    logic [PW-1:0]   gnt_idx;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;
    logic            do_write;
    int              idx;
    int              sel_i;

    // Search starts just past the last winner; grant is suppressed by clear and during reset.
    always_comb begin
        grant   = '0;
        found   = 1'b0;
        gnt_idx = rr_q;
        idx     = 0;
        if (reset && (state_q == ST_ARB) && !iClear) begin
            for (int k = 1; k <= NREQ; k++) begin
                idx = (int'(rr_q) + k) % NREQ;
                if (!found && iReq[idx]) begin
                    found      = 1'b1;
                    grant[idx] = 1'b1;
                    gnt_idx    = PW'(idx);
                end
            end
        end
    end

    always_comb begin
        sel_i    = int'(gnt_idx);
        sel_addr = iReqAddr[sel_i*AW +: AW];
        sel_data = iReqData[sel_i*DW +: DW];
`ifdef RF_ARB_ZERO_GUARD_EN
        do_write = (sel_addr != '0);
`else
        do_write = 1'b1;
`endif
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_ARB: begin
                if (iClear) begin
                    state_d = ST_CLEAR;
                end else if (found) begin
                    rr_d = gnt_idx;
                    if (do_write) begin
                        we_d    = 1'b1;
                        waddr_d = sel_addr;
                        wdata_d = sel_data;
                    end
                end
            end
            ST_CLEAR: begin
                we_d    = 1'b1;
                waddr_d = cnt_q;
                wdata_d = '0;
                if (cnt_q == AW'(NREGS - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_ARB;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_ARB;
            rr_q    <= PW'(NREQ - 1);
            cnt_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign oGrant = grant;
    assign oBusy  = (state_q == ST_CLEAR);
    assign oWe    = we_q;
    assign oWAddr = waddr_q;
    assign oWData = wdata_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb/tb_regfile_wr_arbiter.sv - self-checking bench for regfile_wr_arbiter
module tb_regfile_wr_arbiter;

    localparam int NREQ  = 3;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int NREGS = 32;

    logic               clk;
    logic               reset;
    logic [NREQ-1:0]    iReq;
    logic [NREQ*AW-1:0] iReqAddr;
    logic [NREQ*DW-1:0] iReqData;
    logic [NREQ-1:0]    oGrant;
    logic               iClear;
    logic               oBusy;
    logic [AW-1:0]      oWAddr;
    logic [DW-1:0]      oWData;
    logic               oWe;

    int checks = 0;
    int errors = 0;

    regfile_wr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .NREGS(NREGS)) dut (
        .clk(clk), .reset(reset), .iReq(iReq), .iReqAddr(iReqAddr), .iReqData(iReqData),
        .oGrant(oGrant), .iClear(iClear), .oBusy(oBusy), .oWAddr(oWAddr), .oWData(oWData),
        .oWe(oWe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        iReqAddr[i*AW +: AW] = a;
        iReqData[i*DW +: DW] = d;
    endtask

    task automatic drive_step();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: mode 0 = arbitrating, 1 = clearing.
    int              m_mode = 0, m_last = NREQ - 1, m_cnt = 0;
    logic            m_we = 1'b0;
    logic [AW-1:0]   m_addr = '0;
    logic [DW-1:0]   m_data = '0;
    int              n_mode = 0, n_last = NREQ - 1, n_cnt = 0;
    logic            n_we = 1'b0;
    logic [AW-1:0]   n_addr = '0;
    logic [DW-1:0]   n_data = '0;
    logic [NREQ-1:0] eg;
    int              gi;
    logic            wr_ok;
    logic [DW-1:0]   rf_dut [NREGS];

    always @(negedge clk) begin
        if (!reset) begin
            check("m_rst_grant", oGrant, 0);
            check("m_rst_we", oWe, 0);
            check("m_rst_busy", oBusy, 0);
            n_mode = 0; n_last = NREQ - 1; n_cnt = 0;
            n_we = 1'b0; n_addr = '0; n_data = '0;
        end else begin
            eg = '0;
            gi = -1;
            if (m_mode == 0 && !iClear)
                for (int s = 1; s <= NREQ; s++)
                    if (gi < 0 && iReq[(m_last + s) % NREQ]) gi = (m_last + s) % NREQ;
            if (gi >= 0) eg[gi] = 1'b1;
            check("m_grant", oGrant, eg);
            check("m_busy", oBusy, (m_mode == 1));
            check("m_we", oWe, m_we);
            check("m_waddr", oWAddr, m_addr);
            check("m_wdata", oWData, m_data);
            if (oWe) rf_dut[oWAddr] = oWData;
            n_mode = m_mode; n_last = m_last; n_cnt = m_cnt;
            n_we = 1'b0; n_addr = m_addr; n_data = m_data;
            if (m_mode == 0) begin
                if (iClear) n_mode = 1;
                else if (gi >= 0) begin
                    n_last = gi;
`ifdef RF_ARB_ZERO_GUARD_EN
                    wr_ok = (iReqAddr[gi*AW +: AW] != 0);
`else
                    wr_ok = 1'b1;
`endif
                    if (wr_ok) begin
                        n_we = 1'b1;
                        n_addr = iReqAddr[gi*AW +: AW];
                        n_data = iReqData[gi*DW +: DW];
                    end
                end
            end else begin
                n_we = 1'b1;
                n_addr = AW'(m_cnt);
                n_data = '0;
                n_cnt = (m_cnt == NREGS - 1) ? 0 : m_cnt + 1;
                if (m_cnt == NREGS - 1) n_mode = 0;
            end
        end
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_mode = 0; m_last = NREQ - 1; m_cnt = 0;
            m_we = 1'b0; m_addr = '0; m_data = '0;
        end else begin
            m_mode = n_mode; m_last = n_last; m_cnt = n_cnt;
            m_we = n_we; m_addr = n_addr; m_data = n_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; iReq = '0; iReqAddr = '0; iReqData = '0; iClear = 1'b0;
        #2 reset = 1'b0;
        // T1: reset with all requesting, then rotation 0,1,2,0
        iReq = 3'b111;
        set_req(0, 5'd1, 32'hA0);
        set_req(1, 5'd2, 32'hA1);
        set_req(2, 5'd3, 32'hA2);
        repeat (2) @(negedge clk);
        check("t1_rst_grant", oGrant, 0);
        check("t1_rst_we", oWe, 0);
        drive_step();
        reset = 1'b1;
        @(negedge clk); check("t1_g0", oGrant, 3'b001);
        @(negedge clk); check("t1_g1", oGrant, 3'b010);
        check("t1_we0", oWe, 1); check("t1_a0", oWAddr, 1); check("t1_d0", oWData, 32'hA0);
        @(negedge clk); check("t1_g2", oGrant, 3'b100); check("t1_a1", oWAddr, 2);
        @(negedge clk); check("t1_g3", oGrant, 3'b001); check("t1_a2", oWAddr, 3);
        check("t1_d2", oWData, 32'hA2);
        drive_step(); iReq = '0;
        @(negedge clk); check("t1_we3", oWe, 1); check("t1_a3", oWAddr, 1);
        @(negedge clk); check("t1_idle_we", oWe, 0); check("t1_hold_a", oWAddr, 1);

        // T2: single requester
        drive_step(); iReq = 3'b010; set_req(1, 5'd5, 32'hDEADBEEF);
        @(negedge clk); check("t2_grant", oGrant, 3'b010);
        drive_step(); iReq = '0;
        @(negedge clk); check("t2_we", oWe, 1); check("t2_a", oWAddr, 5);
        check("t2_d", oWData, 32'hDEADBEEF);
        @(negedge clk); check("t2_we_off", oWe, 0);

        // T3: clear with req0 pending, extra iClear mid-sequence ignored
        drive_step(); iClear = 1'b1; iReq = 3'b001; set_req(0, 5'd9, 32'h99);
        @(negedge clk); check("t3_clr_nogrant", oGrant, 0);
        drive_step(); iClear = 1'b0;
        for (int c = 0; c < NREGS; c++) begin
            @(negedge clk);
            check("t3_busy", oBusy, 1);
            check("t3_grant0", oGrant, 0);
            if (c >= 1) begin
                check("t3_we", oWe, 1);
                check("t3_addr", oWAddr, c - 1);
                check("t3_data", oWData, 0);
            end
            if (c == 5) begin drive_step(); iClear = 1'b1; end
            if (c == 6) begin drive_step(); iClear = 1'b0; end
        end
        @(negedge clk); check("t3_busy_off", oBusy, 0); check("t3_req0", oGrant, 3'b001);
        check("t3_last_addr", oWAddr, NREGS - 1); check("t3_last_we", oWe, 1);
        drive_step(); iReq = '0;
        @(negedge clk); check("t3_req0_a", oWAddr, 9); check("t3_req0_d", oWData, 32'h99);
        @(negedge clk);

        // T4: reset in the middle of a clear
        drive_step(); iClear = 1'b1;
        drive_step(); iClear = 1'b0;
        repeat (10) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("t4_we", oWe, 0); check("t4_busy", oBusy, 0); check("t4_grant", oGrant, 0);
        @(negedge clk);
        drive_step(); reset = 1'b1; iReq = 3'b100; set_req(2, 5'd12, 32'h1234);
        @(negedge clk); check("t4_g2", oGrant, 3'b100);
        drive_step(); iReq = '0;
        @(negedge clk); check("t4_we2", oWe, 1); check("t4_a2", oWAddr, 12);
        check("t4_d2", oWData, 32'h1234);

        // T5: same address from req0 and req2, pointer at req0
        drive_step(); iReq = 3'b001; set_req(0, 5'd4, 32'h44);
        @(negedge clk); check("t5_pre", oGrant, 3'b001);
        drive_step(); iReq = 3'b101; set_req(0, 5'd7, 32'h11); set_req(2, 5'd7, 32'h22);
        @(negedge clk); check("t5_first", oGrant, 3'b100);
        drive_step(); iReq = 3'b001;
        @(negedge clk); check("t5_second", oGrant, 3'b001); check("t5_d22", oWData, 32'h22);
        drive_step(); iReq = '0;
        @(negedge clk); check("t5_d11", oWData, 32'h11);
        @(negedge clk); check("t5_final", rf_dut[7], 32'h11);

        // T6: address 0 write
        drive_step(); iReq = 3'b001; set_req(0, 5'd0, 32'hFF);
        @(negedge clk); check("t6_grant", oGrant, 3'b001);
        drive_step(); iReq = '0;
        @(negedge clk);
`ifdef RF_ARB_ZERO_GUARD_EN
        check("t6_we_guard", oWe, 0);
`else
        check("t6_we", oWe, 1); check("t6_a", oWAddr, 0); check("t6_d", oWData, 32'hFF);
`endif
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
